// File: rtl/ics_out_pack_if.sv
// Bus bundle for ics_out_pack: ICS output beats in, packed valid/ready beats out, status flags.
// The master modport is the producer/consumer side; the slave modport is the repacker.
interface ics_out_pack_if #(
  parameter int unsigned ROW_W = 10,
  parameter int unsigned ROWS  = 12
);
  localparam int unsigned DataW = ROW_W * ROWS;
  localparam int unsigned NumW  = $clog2(ROWS + 1);

  logic             ics_out_sof;
  logic             ics_out_eof;
  logic             ics_out_vld;
  logic [NumW-1:0]  ics_out_num;
  logic [DataW-1:0] ics_out_data;

  logic             pk_vld;
  logic             pk_rdy;
  logic             pk_sof;
  logic             pk_eof;
  logic [NumW-1:0]  pk_num;
  logic [DataW-1:0] pk_data;
  logic             pk_busy;
  logic             pk_ovf;
  logic             pk_err;

  modport master (
    output ics_out_sof, ics_out_eof, ics_out_vld, ics_out_num, ics_out_data, pk_rdy,
    input  pk_vld, pk_sof, pk_eof, pk_num, pk_data, pk_busy, pk_ovf, pk_err
  );

  modport slave (
    input  ics_out_sof, ics_out_eof, ics_out_vld, ics_out_num, ics_out_data, pk_rdy,
    output pk_vld, pk_sof, pk_eof, pk_num, pk_data, pk_busy, pk_ovf, pk_err
  );
endinterface

// File: rtl/ics_out_pack.sv
// Repacks variable-size ICS output beats into dense ROWS-row beats and buffers them in a small
// FIFO behind a valid/ready stream, since the ICS core itself cannot be backpressured.
module ics_out_pack #(
  parameter int unsigned ROW_W      = 10,
  parameter int unsigned ROWS       = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  ics_out_pack_if.slave bus
);
  localparam int unsigned DataW = ROW_W * ROWS;
  localparam int unsigned ResW  = ROW_W * (ROWS - 1);
  localparam int unsigned CombW = DataW + ResW;
  localparam int unsigned ShW   = $clog2(CombW);
  localparam int unsigned NumW  = $clog2(ROWS + 1);
  localparam int unsigned TotW  = NumW + 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [NumW-1:0] RowsN  = NumW'(ROWS);
  localparam logic [TotW-1:0] RowsT  = TotW'(ROWS);
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  typedef struct packed {
    logic             sof;
    logic             eof;
    logic [NumW-1:0]  num;
    logic [DataW-1:0] data;
  } ent_t;

  state_e          state_q, state_d;
  logic [ResW-1:0] res_q, res_d;
  logic [NumW-1:0] res_cnt_q, res_cnt_d;
  logic            sof_pend_q, sof_pend_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  ent_t            mem_q [FIFO_DEPTH];

  logic             num_ok, acc, big, rd, drop, we0, we1;
  logic [NumW-1:0]  eff_cnt;
  logic [TotW-1:0]  tot;
  logic [ShW-1:0]   shamt;
  logic [DataW-1:0] in_rows;
  logic [ResW-1:0]  res_rows;
  logic [CombW-1:0] comb;
  logic [1:0]       nwr, nwr_done;
  logic [CntW-1:0]  free;
  logic [PtrW-1:0]  wr_ptr1;
  ent_t             ent0, ent1, head;

  function automatic logic [DataW-1:0] row_mask(logic [NumW-1:0] n);
    logic [DataW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (NumW'(i) < n) m[i*ROW_W +: ROW_W] = '1;
    end
    return m;
  endfunction

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    res_cnt_d  = res_cnt_q;
    sof_pend_d = sof_pend_q;
    ovf_d      = ovf_q;
    err_d      = err_q;

    num_ok = (bus.ics_out_num != '0) && (bus.ics_out_num <= RowsN);
    acc    = bus.ics_out_vld && num_ok && (bus.ics_out_sof || state_q == StActive);
    if (bus.ics_out_vld && (!num_ok || (bus.ics_out_sof == (state_q == StActive)))) begin
      err_d = 1'b1;
    end

    // A frame start drops any residue left over from an unterminated frame.
    eff_cnt  = bus.ics_out_sof ? '0 : res_cnt_q;
    res_rows = bus.ics_out_sof ? '0 : res_q;
    tot      = {1'b0, eff_cnt} + {1'b0, bus.ics_out_num};
    shamt    = ShW'(ROW_W) * ShW'(eff_cnt);
    in_rows  = bus.ics_out_data & row_mask(bus.ics_out_num);
    // Residue and inputs are kept zero above their row counts, so comb is already clean.
    comb     = ({{ResW{1'b0}}, in_rows} << shamt) | {{DataW{1'b0}}, res_rows};
    big      = tot > RowsT;

    nwr = 2'd0;
    if (acc) begin
      if (bus.ics_out_eof) nwr = big ? 2'd2 : 2'd1;
      else if (tot >= RowsT) nwr = 2'd1;
    end

    ent0.sof  = bus.ics_out_sof || sof_pend_q;
    ent0.eof  = bus.ics_out_eof && !big;
    ent0.num  = (tot >= RowsT) ? RowsN : NumW'(tot);
    ent0.data = comb[DataW-1:0];
    ent1.sof  = 1'b0;
    ent1.eof  = 1'b1;
    ent1.num  = NumW'(tot - RowsT);
    ent1.data = {{(DataW - ResW){1'b0}}, comb[CombW-1:DataW]};

    rd       = (cnt_q != '0) && bus.pk_rdy;
    free     = DepthC - cnt_q + CntW'(rd);
    drop     = CntW'(nwr) > free;
    we0      = (nwr != 2'd0) && !drop;
    we1      = (nwr == 2'd2) && !drop;
    nwr_done = {1'b0, we0} + {1'b0, we1};
    wr_ptr1  = wr_ptr_q + PtrW'(1);

    wr_ptr_d = wr_ptr_q + PtrW'(nwr_done);
    rd_ptr_d = rd_ptr_q + PtrW'(rd);
    cnt_d    = cnt_q + CntW'(nwr_done) - CntW'(rd);
    if ((nwr != 2'd0) && drop) ovf_d = 1'b1;

    if (acc) begin
      state_d    = bus.ics_out_eof ? StIdle : StActive;
      sof_pend_d = (nwr != 2'd0) ? 1'b0 : ent0.sof;
      if (bus.ics_out_eof) begin
        res_d     = '0;
        res_cnt_d = '0;
      end else if (tot >= RowsT) begin
        res_d     = comb[CombW-1:DataW];
        res_cnt_d = NumW'(tot - RowsT);
      end else begin
        res_d     = comb[ResW-1:0];
        res_cnt_d = NumW'(tot);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      res_q      <= '0;
      res_cnt_q  <= '0;
      sof_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      res_cnt_q  <= res_cnt_d;
      sof_pend_q <= sof_pend_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) mem_q[wr_ptr_q] <= ent0;
    if (we1) mem_q[wr_ptr1] <= ent1;
  end

  // Gate the head entry so every output reads 0 while the FIFO is empty or in reset.
  assign head = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;

  assign bus.pk_vld  = cnt_q != '0;
  assign bus.pk_sof  = head.sof;
  assign bus.pk_eof  = head.eof;
  assign bus.pk_num  = head.num;
  assign bus.pk_data = head.data;
  assign bus.pk_busy = (state_q == StActive) || (cnt_q != '0);
  assign bus.pk_ovf  = ovf_q;
  assign bus.pk_err  = err_q;
endmodule
